// File: rtl/spectral_scaler.sv
// Pitch-shift stage: remaps each output bin to a source bin via a Q8.8 ratio,
// scales magnitude by a Q8.8 gain and fills one of two ping-pong buffer pairs.
module spectral_scaler #(
  parameter int NUM_BINS = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go_in,
  input  logic [15:0] ratio,
  input  logic [15:0] gain,
  output logic [11:0] in_mag_addr,
  output logic [11:0] in_phase_addr,
  input  logic [15:0] in_mag_data,
  input  logic [15:0] in_phase_data,
  output logic [11:0] mag_buf_0_addr,
  output logic [15:0] mag_buf_0_data,
  output logic        mag_buf_0_wren,
  output logic [11:0] phase_buf_0_addr,
  output logic [15:0] phase_buf_0_data,
  output logic        phase_buf_0_wren,
  output logic [11:0] mag_buf_1_addr,
  output logic [15:0] mag_buf_1_data,
  output logic        mag_buf_1_wren,
  output logic [11:0] phase_buf_1_addr,
  output logic [15:0] phase_buf_1_data,
  output logic        phase_buf_1_wren,
  output logic        go_out,
  output logic        cur_window,
  output logic        busy,
  output logic        overrun
);

  localparam logic [11:0] LAST_BIN  = 12'(NUM_BINS - 1);
  localparam logic [19:0] BIN_LIMIT = 20'(NUM_BINS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        drain_reg;
  logic        wr_sel_reg;
  logic        cur_window_reg;
  logic        overrun_reg;
  logic [15:0] ratio_reg;
  logic [15:0] gain_reg;
  logic [11:0] rd_addr_reg;
  logic [11:0] s1_bin_reg;
  logic        s1_oor_reg;
  logic [11:0] s2_bin_reg;
  logic        s2_oor_reg;
  logic        s2_valid_reg;

  logic        accept;
  logic        last_bin;
  logic [11:0] next_bin;
  logic [19:0] next_src;
  logic [23:0] mag_scaled;
  logic [15:0] wr_mag;
  logic [15:0] wr_phase;

  assign accept     = (state_reg == IDLE) && go_in;
  assign last_bin   = (s1_bin_reg == LAST_BIN);
  assign next_bin   = s1_bin_reg + 12'd1;
  assign next_src   = 20'((28'(next_bin) * 28'(ratio_reg)) >> 8);
  assign mag_scaled = 24'((32'(in_mag_data) * 32'(gain_reg)) >> 8);

  // Out-of-range source bins are zeroed; the read still happens but is discarded.
  assign wr_mag   = s2_oor_reg ? 16'h0000 :
                    ((|mag_scaled[23:16]) ? 16'hFFFF : mag_scaled[15:0]);
  assign wr_phase = s2_oor_reg ? 16'h0000 : in_phase_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go_in) state_next = RUN;
      RUN:     if (last_bin) state_next = DRAIN;
      DRAIN:   if (drain_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_reg != IDLE);
    go_out = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drain_reg      <= 1'b0;
      wr_sel_reg     <= 1'b1;
      cur_window_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      ratio_reg      <= 16'h0000;
      gain_reg       <= 16'h0000;
      rd_addr_reg    <= 12'h000;
      s1_bin_reg     <= 12'h000;
      s1_oor_reg     <= 1'b0;
      s2_bin_reg     <= 12'h000;
      s2_oor_reg     <= 1'b0;
      s2_valid_reg   <= 1'b0;
    end else begin
      drain_reg   <= (state_reg == DRAIN) && !drain_reg;
      overrun_reg <= go_in && (state_reg != IDLE);
      if ((state_reg == DRAIN) && drain_reg) begin
        cur_window_reg <= wr_sel_reg;
      end
      // Bin 0 always maps to source 0, so its address is issued straight from acceptance.
      if (accept) begin
        ratio_reg   <= ratio;
        gain_reg    <= gain;
        wr_sel_reg  <= !wr_sel_reg;
        rd_addr_reg <= 12'h000;
        s1_bin_reg  <= 12'h000;
        s1_oor_reg  <= 1'b0;
      end else if ((state_reg == RUN) && !last_bin) begin
        rd_addr_reg <= next_src[11:0];
        s1_bin_reg  <= next_bin;
        s1_oor_reg  <= (next_src >= BIN_LIMIT);
      end
      s2_valid_reg <= (state_reg == RUN);
      s2_bin_reg   <= s1_bin_reg;
      s2_oor_reg   <= s1_oor_reg;
    end
  end

  assign in_mag_addr   = rd_addr_reg;
  assign in_phase_addr = rd_addr_reg;
  assign cur_window    = cur_window_reg;
  assign overrun       = overrun_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      localparam logic PAIR_ID = 1'(gi);
      logic [11:0] addr_reg;
      logic [15:0] mag_reg;
      logic [15:0] phase_reg;
      logic        wren_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          addr_reg  <= 12'h000;
          mag_reg   <= 16'h0000;
          phase_reg <= 16'h0000;
          wren_reg  <= 1'b0;
        end else begin
          wren_reg <= s2_valid_reg && (wr_sel_reg == PAIR_ID);
          if (s2_valid_reg && (wr_sel_reg == PAIR_ID)) begin
            addr_reg  <= s2_bin_reg;
            mag_reg   <= wr_mag;
            phase_reg <= wr_phase;
          end
        end
      end
    end
  endgenerate

  assign mag_buf_0_addr   = g_pair[0].addr_reg;
  assign mag_buf_0_data   = g_pair[0].mag_reg;
  assign mag_buf_0_wren   = g_pair[0].wren_reg;
  assign phase_buf_0_addr = g_pair[0].addr_reg;
  assign phase_buf_0_data = g_pair[0].phase_reg;
  assign phase_buf_0_wren = g_pair[0].wren_reg;
  assign mag_buf_1_addr   = g_pair[1].addr_reg;
  assign mag_buf_1_data   = g_pair[1].mag_reg;
  assign mag_buf_1_wren   = g_pair[1].wren_reg;
  assign phase_buf_1_addr = g_pair[1].addr_reg;
  assign phase_buf_1_data = g_pair[1].phase_reg;
  assign phase_buf_1_wren = g_pair[1].wren_reg;

endmodule

// File: tb/tb_spectral_scaler.sv
// Bench for spectral_scaler: per-cycle comparison against a window-level model
// plus literal expectations on the captured output buffers.
module tb_spectral_scaler;
  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go_in;
  logic [15:0] ratio;
  logic [15:0] gain;
  logic [11:0] in_mag_addr, in_phase_addr;
  logic [15:0] in_mag_data = '0;
  logic [15:0] in_phase_data = '0;
  logic [11:0] mag_buf_0_addr, phase_buf_0_addr, mag_buf_1_addr, phase_buf_1_addr;
  logic [15:0] mag_buf_0_data, phase_buf_0_data, mag_buf_1_data, phase_buf_1_data;
  logic        mag_buf_0_wren, phase_buf_0_wren, mag_buf_1_wren, phase_buf_1_wren;
  logic        go_out, cur_window, busy, overrun;

  spectral_scaler #(.NUM_BINS(N)) dut (
    .clk(clk), .reset_n(reset_n), .go_in(go_in), .ratio(ratio), .gain(gain),
    .in_mag_addr(in_mag_addr), .in_phase_addr(in_phase_addr),
    .in_mag_data(in_mag_data), .in_phase_data(in_phase_data),
    .mag_buf_0_addr(mag_buf_0_addr), .mag_buf_0_data(mag_buf_0_data), .mag_buf_0_wren(mag_buf_0_wren),
    .phase_buf_0_addr(phase_buf_0_addr), .phase_buf_0_data(phase_buf_0_data), .phase_buf_0_wren(phase_buf_0_wren),
    .mag_buf_1_addr(mag_buf_1_addr), .mag_buf_1_data(mag_buf_1_data), .mag_buf_1_wren(mag_buf_1_wren),
    .phase_buf_1_addr(phase_buf_1_addr), .phase_buf_1_data(phase_buf_1_data), .phase_buf_1_wren(phase_buf_1_wren),
    .go_out(go_out), .cur_window(cur_window), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Upstream buffers (1-cycle read latency) and captured downstream buffers.
  logic [15:0] src_mag [N];
  logic [15:0] src_phase [N];
  logic [15:0] cap_mag0 [N];
  logic [15:0] cap_phase0 [N];
  logic [15:0] cap_mag1 [N];
  logic [15:0] cap_phase1 [N];

  always @(posedge clk) begin
    in_mag_data   <= src_mag[in_mag_addr];
    in_phase_data <= src_phase[in_phase_addr];
    if (mag_buf_0_wren)   cap_mag0[mag_buf_0_addr]     <= mag_buf_0_data;
    if (phase_buf_0_wren) cap_phase0[phase_buf_0_addr] <= phase_buf_0_data;
    if (mag_buf_1_wren)   cap_mag1[mag_buf_1_addr]     <= mag_buf_1_data;
    if (phase_buf_1_wren) cap_phase1[phase_buf_1_addr] <= phase_buf_1_data;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Window-level model: one active window described by its start cycle and parameters.
  bit          win_on = 1'b0;
  int          win_t = 0;
  bit          win_pair = 1'b0;
  logic [15:0] win_ratio = '0;
  logic [15:0] win_gain = '0;
  bit          next_pair = 1'b0;
  bit          cur_exp = 1'b0;
  int          ovr_cyc = -1;

  function automatic logic [19:0] src_of(input int j);
    longint p;
    p = longint'(j) * longint'(win_ratio);
    return 20'(p >> 8);
  endfunction

  function automatic logic [15:0] exp_mag(input int j);
    logic [19:0] s;
    longint m;
    s = src_of(j);
    if (s >= 20'(N)) return 16'h0000;
    m = (longint'(src_mag[s[11:0]]) * longint'(win_gain)) >> 8;
    return (m > 65535) ? 16'hFFFF : 16'(m);
  endfunction

  function automatic logic [15:0] exp_phase(input int j);
    logic [19:0] s;
    s = src_of(j);
    if (s >= 20'(N)) return 16'h0000;
    return src_phase[s[11:0]];
  endfunction

  function automatic logic any_out();
    return |{in_mag_addr, in_phase_addr,
             mag_buf_0_addr, mag_buf_0_data, mag_buf_0_wren,
             phase_buf_0_addr, phase_buf_0_data, phase_buf_0_wren,
             mag_buf_1_addr, mag_buf_1_data, mag_buf_1_wren,
             phase_buf_1_addr, phase_buf_1_data, phase_buf_1_wren,
             go_out, cur_window, busy, overrun};
  endfunction

  always @(negedge clk) begin : compare
    int k, j;
    logic [19:0] s;
    logic busy_e, go_e, wr_e;
    if (!reset_n) begin
      check("reset_outputs", any_out(), 1'b0);
    end else begin
      k      = cyc;
      busy_e = win_on && (k >= win_t + 1) && (k <= win_t + 3 + N);
      go_e   = win_on && (k == win_t + 3 + N);
      if (go_e) cur_exp = win_pair;
      check("busy", busy, busy_e);
      check("go_out", go_out, go_e);
      check("cur_window", cur_window, cur_exp);
      check("overrun", overrun, k == ovr_cyc);
      if (win_on && (k >= win_t + 1) && (k <= win_t + N)) begin
        j = k - win_t - 1;
        s = src_of(j);
        check("rd_addr", {in_mag_addr, in_phase_addr}, {s[11:0], s[11:0]});
      end
      wr_e = win_on && (k >= win_t + 3) && (k <= win_t + 2 + N);
      check("wren_pair0", {mag_buf_0_wren, phase_buf_0_wren}, {2{wr_e && !win_pair}});
      check("wren_pair1", {mag_buf_1_wren, phase_buf_1_wren}, {2{wr_e && win_pair}});
      if (wr_e) begin
        j = k - win_t - 3;
        if (!win_pair)
          check("write_pair0", {mag_buf_0_addr, phase_buf_0_addr, mag_buf_0_data, phase_buf_0_data},
                {12'(j), 12'(j), exp_mag(j), exp_phase(j)});
        else
          check("write_pair1", {mag_buf_1_addr, phase_buf_1_addr, mag_buf_1_data, phase_buf_1_data},
                {12'(j), 12'(j), exp_mag(j), exp_phase(j)});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    if (cyc > c) begin
      n_total++;
      $display("FAIL wait_until: at cycle %0d, required at most %0d", cyc, c);
    end
    while (cyc < c) step(1);
  endtask

  // Drives go_in for exactly one cycle; the model decides acceptance vs. overrun.
  task automatic drive_go(input logic [15:0] r, input logic [15:0] g);
    int k;
    k = cyc;
    go_in = 1'b1;
    ratio = r;
    gain  = g;
    if (win_on && (k <= win_t + 3 + N)) begin
      ovr_cyc = k + 1;
    end else begin
      win_on    = 1'b1;
      win_t     = k;
      win_pair  = next_pair;
      next_pair = !next_pair;
      win_ratio = r;
      win_gain  = g;
    end
    step(1);
    go_in = 1'b0;
  endtask

  task automatic wait_go(output int g);
    bit seen;
    seen = 1'b0;
    g = -1;
    for (int i = 0; i < 5000 && !seen; i++) begin
      step(1);
      if (go_out) begin
        seen = 1'b1;
        g = cyc;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL go_wait: got no go_out in 5000 cycles, required one");
    end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < N; i++) begin
      src_mag[i]   = 16'(i);
      src_phase[i] = ~16'(i);
    end
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < N; i++) src_mag[i] = v;
  endtask

  initial begin : stimulus
    int t, g;
    reset_n = 1'b0;
    go_in   = 1'b0;
    ratio   = '0;
    gain    = '0;
    fill_identity();
    for (int i = 0; i < N; i++) begin
      cap_mag0[i] = '0; cap_phase0[i] = '0; cap_mag1[i] = '0; cap_phase1[i] = '0;
    end
    step(3);
    check("rst_all_zero", any_out(), 1'b0);
    reset_n = 1'b1;
    step(2);
    check("idle_busy", busy, 1'b0);

    // Identity window -> pair 0
    drive_go(16'h0100, 16'h0100);
    t = win_t;
    wait_go(g);
    $display("window identity: go_out at %0d, cur_window %0d", g - t, cur_window);
    check("w1_go_cycle", g, t + 4099);
    check("w1_cur", cur_window, 1'b0);
    check("w1_mag5", cap_mag0[5], 16'd5);
    check("w1_ph4095", cap_phase0[4095], 16'hF000);

    // Octave up -> pair 1
    step(5);
    drive_go(16'h0080, 16'h0100);
    wait_go(g);
    $display("window octave-up: cur_window %0d", cur_window);
    check("w2_cur", cur_window, 1'b1);
    check("w2_mag7", cap_mag1[7], 16'd3);
    check("w2_mag4095", cap_mag1[4095], 16'd2047);
    check("w2_ph7", cap_phase1[7], 16'hFFFC);

    // go_in on the go_out cycle is ignored; next cycle starts octave down -> pair 0
    drive_go(16'h0300, 16'h0100);
    drive_go(16'h0200, 16'h0100);
    wait_go(g);
    $display("window octave-down: cur_window %0d", cur_window);
    check("w3_cur", cur_window, 1'b0);
    check("w3_mag100", cap_mag0[100], 16'd200);
    check("w3_ph100", cap_phase0[100], 16'hFF37);
    check("w3_mag2047", cap_mag0[2047], 16'd4094);
    check("w3_mag3000", cap_mag0[3000], 16'h0000);
    check("w3_ph3000", cap_phase0[3000], 16'h0000);

    // Back-to-back gain windows -> pair 1 then pair 0
    fill_const(16'h9000);
    step(1);
    drive_go(16'h0100, 16'h0200);
    wait_go(g);
    $display("window gain x2: cur_window %0d", cur_window);
    check("w4_cur", cur_window, 1'b1);
    check("w4_sat", cap_mag1[10], 16'hFFFF);
    check("w4_ph10", cap_phase1[10], 16'hFFF5);
    step(1);
    drive_go(16'h0100, 16'h0080);
    wait_go(g);
    $display("window gain x0.5: cur_window %0d", cur_window);
    check("w5_cur", cur_window, 1'b0);
    check("w5_half", cap_mag0[10], 16'h4800);

    // Overrun mid-window -> pair 1, latched parameters unchanged
    fill_identity();
    step(3);
    drive_go(16'h0100, 16'h0100);
    t = win_t;
    wait_until(t + 100);
    drive_go(16'h0200, 16'h0300);
    wait_go(g);
    $display("window overrun: go_out at %0d, cur_window %0d", g - t, cur_window);
    check("w6_go_cycle", g, t + 4099);
    check("w6_cur", cur_window, 1'b1);
    check("w6_mag3000", cap_mag1[3000], 16'd3000);

    // Asynchronous reset mid-window
    fill_const(16'h1234);
    step(3);
    drive_go(16'h0100, 16'h0100);
    t = win_t;
    wait_until(t + 2000);
    #2;
    reset_n   = 1'b0;
    win_on    = 1'b0;
    next_pair = 1'b0;
    cur_exp   = 1'b0;
    ovr_cyc   = -1;
    #1;
    $display("async reset at window cycle %0d", cyc - t);
    check("async_rst_zero", any_out(), 1'b0);
    step(3);
    reset_n = 1'b1;
    wait_until(t + 4300);

    // After reset the next window fills pair 0 again
    fill_identity();
    drive_go(16'h0100, 16'h0100);
    wait_go(g);
    $display("window post-reset: cur_window %0d", cur_window);
    check("w8_cur", cur_window, 1'b0);
    check("w8_mag1500", cap_mag0[1500], 16'd1500);
    check("w8_mag3000", cap_mag0[3000], 16'd3000);
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spectral_scaler.md
# spectral_scaler

Pitch-shift stage between the Cartesian-to-polar converter and `polar_to_cart`. Per window, it remaps each output frequency bin to a source bin via a fixed-point ratio, applies a magnitude gain, and writes the result into one of two ping-pong magnitude/phase buffer pairs. When the window is complete it issues a single-cycle `go_out` to `polar_to_cart`, with `cur_window` naming the buffer pair just filled.

## Interface
- NUM_BINS, 4096: bins per window; power of two, at most 4096 (12-bit addresses).
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- go_in  in  1  one-cycle start pulse from upstream; input buffers hold a complete window.
- ratio  in  16  unsigned Q8.8 source-step ratio, equal to 1/pitch_factor; sampled at accepted go_in.
- gain  in  16  unsigned Q8.8 magnitude gain; sampled at accepted go_in.
- in_mag_addr / in_phase_addr  out  12  read addresses into the upstream magnitude and phase buffers.
- in_mag_data / in_phase_data  in  16  read data, valid exactly 1 cycle after the address.
- mag_buf_0_addr, mag_buf_0_data, mag_buf_0_wren  out  12/16/1  write port of magnitude buffer 0.
- phase_buf_0_addr, phase_buf_0_data, phase_buf_0_wren  out  12/16/1  write port of phase buffer 0.
- mag_buf_1_*, phase_buf_1_*  out  12/16/1  same ports for buffer pair 1.
- go_out  out  1  one-cycle pulse; the window is complete in pair `cur_window`.
- cur_window  out  1  index of the most recently completed pair; held until the next completion.
- busy  out  1  high from go_in acceptance until the go_out cycle (inclusive).
- overrun  out  1  one-cycle pulse when go_in arrives while busy.

## Operation
- States:
  - IDLE: on go_in, latch ratio and gain, set wr_sel to NOT wr_sel, j=0, then go to RUN.
  - RUN: issue one output bin per cycle, j = 0..NUM_BINS-1; after the last bin go to DRAIN.
  - DRAIN: 2 cycles to flush the pipeline, then go to DONE.
  - DONE: 1 cycle; pulse go_out, set cur_window to wr_sel, then go to IDLE.
- Source bin: src = (j × ratio_q) >> 8, with a 28-bit product and 20-bit result. The input read address is src[11:0].
- Out-of-range bins: if src ≥ NUM_BINS, the stage writes magnitude 0 and phase 0 for bin j. The read is still issued, and its data is ignored.
- Magnitude: m = (in_mag × gain_q) >> 8, with a 32-bit product. If m > 16'hFFFF, the output saturates to 16'hFFFF.
- Phase: copied unchanged from in_phase.
- Write target: only the pair selected by wr_sel receives wren. Both wren bits of the other pair stay 0 for the whole window. Magnitude and phase in the selected pair share the same addr and wren every cycle.
- go_in in RUN, DRAIN or DONE: ignored (no restart, latched values unchanged) and overrun pulses.
- go_in in the same cycle as the DONE→IDLE transition: ignored, with overrun.

## Timing
- Reset values:
  - All addr, data and wren outputs: 0.
  - go_out, busy, overrun: 0.
  - cur_window: 0.
  - Internal wr_sel: 1, so the first window fills pair 0.
- Schedule, with go_in accepted at cycle T:
  - busy rises at T+1.
  - Read addresses for bin j are presented at T+1+j.
  - Read data is registered at T+2+j.
  - The write of bin j (wren=1, addr=j) occurs at T+3+j.
  - The last write is at T+2+NUM_BINS.
  - go_out and the new cur_window appear at T+3+NUM_BINS.
  - busy falls at T+4+NUM_BINS.
- Write ports are fully registered; wren is never asserted outside the write window.
- Throughput: one window per NUM_BINS+4 cycles. The next go_in is accepted from T+4+NUM_BINS onward.
- Asynchronous reset mid-window: all outputs return to reset values immediately. The partially written buffer contents are undefined, and no go_out is issued.

## Test plan
- Identity: ratio=0x0100, gain=0x0100, in_mag[i]=i, in_phase[i]=~i → pair 0 holds mag[j]=j and phase[j]=~j; go_out at T+4099 with cur_window=0.
- Octave up: ratio=0x0080 → mag[j]=in_mag[j>>1]. Octave down: ratio=0x0200 → mag[j]=in_mag[2j] for j<2048, and mag=phase=0 for j≥2048.
- Gain saturation: gain=0x0200, in_mag=0x9000 → 0xFFFF. gain=0x0080, in_mag=0x9000 → 0x4800.
- Ping-pong: three back-to-back windows → cur_window sequence 0,1,0, with no wren on the inactive pair in any window.
- Overrun: go_in at T+100 → overrun high for 1 cycle; output unchanged and go_out still at T+4099.
- Reset at T+2000 → all outputs 0 asynchronously, no go_out. A subsequent go_in fills pair 0 again.
